// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch controller.
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2
  } sw_state_e;

  localparam int unsigned BcdW = 4;

  localparam logic [BcdW-1:0] DigitMax9 = 4'd9;
  localparam logic [BcdW-1:0] DigitMax5 = 4'd5;

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD digit counting 0..Max, with enable, ripple carry in/out and
// synchronous clear.
module bcd_digit_cnt
  import stopwatch_pkg::*;
#(
  parameter logic [BcdW-1:0] Max = DigitMax9
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  input  logic            carry_in,
  input  logic            clear,
  output logic [BcdW-1:0] q,
  output logic            carry_out
);

  logic [BcdW-1:0] cnt_q, cnt_d;
  logic            at_max;

  // >= rather than == so a corrupted value still snaps back into range
  assign at_max    = (cnt_q >= Max);
  assign carry_out = en & carry_in & at_max;
  assign q         = cnt_q;

  // Next digit value: clear has priority over counting.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (en && carry_in) begin
      cnt_d = at_max ? '0 : cnt_q + 1'b1;
    end
  end

  // Digit register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch controller: synchronises the 100 Hz divided clock into a tick,
// runs an IDLE/RUN/PAUSE FSM and a six-digit MM:SS.cc BCD counter.
// Optional lap-hold display freeze is built when STOPWATCH_LAP_EN is defined.
module stopwatch_ctrl
  import stopwatch_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            div_clk,
  input  logic            btn_start,
  input  logic            btn_clear,
  input  logic            btn_lap,
  output logic [BcdW-1:0] m_tens,
  output logic [BcdW-1:0] m_ones,
  output logic [BcdW-1:0] s_tens,
  output logic [BcdW-1:0] s_ones,
  output logic [BcdW-1:0] cs_tens,
  output logic [BcdW-1:0] cs_ones,
  output logic            running,
  output logic            wrap,
  output logic            lap_active
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   edge_q;
  logic                   tick_q;
  sw_state_e              state_q;
  logic                   running_q;
  logic                   wrap_q;
  logic                   clr_req;
  logic                   count_en;
  logic [6*BcdW-1:0]      live;
  logic [6*BcdW-1:0]      disp;
  logic [5:0]             carry;

  // div_clk is data: synchronise, detect the rising edge, register the tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      edge_q <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
      edge_q <= sync_q[SYNC_STAGES-1];
      tick_q <= sync_q[SYNC_STAGES-1] & ~edge_q;
    end
  end

  // Clear is only honoured outside RUN; in RUN a coincident start wins.
  assign clr_req  = btn_clear && (state_q != StRun);
  assign count_en = tick_q && (state_q == StRun);

  // Run/pause FSM with registered running flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      running_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (!btn_clear && btn_start) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        StRun: begin
          if (btn_start) begin
            state_q   <= StPause;
            running_q <= 1'b0;
          end
        end
        StPause: begin
          if (btn_clear) begin
            state_q   <= StIdle;
            running_q <= 1'b0;
          end else if (btn_start) begin
            state_q   <= StRun;
            running_q <= 1'b1;
          end
        end
        default: begin
          state_q   <= StIdle;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  bcd_digit_cnt #(.Max(DigitMax9)) u_cs_ones (
    .clk(clk), .rst_n(rst_n), .en(count_en), .carry_in(1'b1), .clear(clr_req),
    .q(live[3:0]), .carry_out(carry[0])
  );
  bcd_digit_cnt #(.Max(DigitMax9)) u_cs_tens (
    .clk(clk), .rst_n(rst_n), .en(count_en), .carry_in(carry[0]), .clear(clr_req),
    .q(live[7:4]), .carry_out(carry[1])
  );
  bcd_digit_cnt #(.Max(DigitMax9)) u_s_ones (
    .clk(clk), .rst_n(rst_n), .en(count_en), .carry_in(carry[1]), .clear(clr_req),
    .q(live[11:8]), .carry_out(carry[2])
  );
  bcd_digit_cnt #(.Max(DigitMax5)) u_s_tens (
    .clk(clk), .rst_n(rst_n), .en(count_en), .carry_in(carry[2]), .clear(clr_req),
    .q(live[15:12]), .carry_out(carry[3])
  );
  bcd_digit_cnt #(.Max(DigitMax9)) u_m_ones (
    .clk(clk), .rst_n(rst_n), .en(count_en), .carry_in(carry[3]), .clear(clr_req),
    .q(live[19:16]), .carry_out(carry[4])
  );
  bcd_digit_cnt #(.Max(DigitMax5)) u_m_tens (
    .clk(clk), .rst_n(rst_n), .en(count_en), .carry_in(carry[4]), .clear(clr_req),
    .q(live[23:20]), .carry_out(carry[5])
  );

  // Rollover pulse, aligned with the digits returning to 00:00.00.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrap_q <= 1'b0;
    end else begin
      wrap_q <= carry[5];
    end
  end

`ifdef STOPWATCH_LAP_EN
  logic              lap_q;
  logic [6*BcdW-1:0] snap_q;

  // Lap hold: toggled in RUN, released in PAUSE or on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lap_q  <= 1'b0;
      snap_q <= '0;
    end else if (clr_req) begin
      lap_q <= 1'b0;
    end else if (btn_lap) begin
      if (state_q == StRun) begin
        if (lap_q) begin
          lap_q <= 1'b0;
        end else begin
          lap_q  <= 1'b1;
          snap_q <= live;
        end
      end else if (state_q == StPause) begin
        lap_q <= 1'b0;
      end
    end
  end

  assign disp       = lap_q ? snap_q : live;
  assign lap_active = lap_q;
`else
  logic unused_lap;
  assign unused_lap = btn_lap;
  assign disp       = live;
  assign lap_active = 1'b0;
`endif

  assign {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones} = disp;
  assign running = running_q;
  assign wrap    = wrap_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus random
// button/div_clk traffic, all checked every cycle against a centisecond model.
module tb_stopwatch_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic div_clk = 1'b0;
  logic btn_start = 1'b0;
  logic btn_clear = 1'b0;
  logic btn_lap = 1'b0;
  logic [3:0] m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones;
  logic running, wrap, lap_active;

  stopwatch_ctrl #(.SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .div_clk(div_clk),
    .btn_start(btn_start), .btn_clear(btn_clear), .btn_lap(btn_lap),
    .m_tens(m_tens), .m_ones(m_ones), .s_tens(s_tens), .s_ones(s_ones),
    .cs_tens(cs_tens), .cs_ones(cs_ones),
    .running(running), .wrap(wrap), .lap_active(lap_active)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int wrap_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: elapsed time as a plain centisecond count.
  localparam int MIdle = 0, MRun = 1, MPause = 2;
  int m_st, m_cs, m_snap;
  bit m_lap, m_wrap;
  bit h[4];  // div_clk as sampled on the previous four edges, newest first

  task automatic model_reset();
    m_st = MIdle; m_cs = 0; m_snap = 0; m_lap = 0; m_wrap = 0;
    for (int i = 0; i < 4; i++) h[i] = 0;
  endtask

  // One clock edge of behaviour, using the inputs present at that edge.
  task automatic model_update();
    bit tick;
    tick = h[2] & ~h[3];  // rise seen three edges ago -> counted now
    h[3] = h[2]; h[2] = h[1]; h[1] = h[0]; h[0] = div_clk;
    m_wrap = 0;
`ifdef STOPWATCH_LAP_EN
    if (btn_clear && m_st != MRun) m_lap = 0;
    else if (btn_lap && m_st == MRun) begin
      if (m_lap) m_lap = 0;
      else begin m_lap = 1; m_snap = m_cs; end
    end else if (btn_lap && m_st == MPause) m_lap = 0;
`endif
    if (m_st == MRun && tick) begin
      m_cs++;
      if (m_cs == 360000) begin m_cs = 0; m_wrap = 1; end
    end
    case (m_st)
      MIdle:  if (!btn_clear && btn_start) m_st = MRun;
      MRun:   if (btn_start) m_st = MPause;
      default: begin
        if (btn_clear) begin m_st = MIdle; m_cs = 0; end
        else if (btn_start) m_st = MRun;
      end
    endcase
  endtask

  function automatic logic [23:0] to_bcd(input int c);
    int mm, ss, cc;
    mm = c / 6000; ss = (c / 100) % 60; cc = c % 100;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), 4'(cc / 10), 4'(cc % 10)};
  endfunction

  function automatic logic [31:0] exp_bundle();
    int d;
    d = m_lap ? m_snap : m_cs;
    return {5'd0, to_bcd(d), (m_st == MRun), m_wrap, m_lap};
  endfunction

  function automatic logic [23:0] digs();
    return {m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones};
  endfunction

  function automatic logic [31:0] obs_bundle();
    return {5'd0, digs(), running, wrap, lap_active};
  endfunction

  // Advance one clock with current inputs, then compare on the falling edge.
  task automatic step();
    @(posedge clk);
    if (rst_n) model_update();
    @(negedge clk);
    if (wrap) wrap_cnt++;
    check_eq("cycle", obs_bundle(), exp_bundle());
  endtask

  task automatic press(input bit s, input bit c, input bit l);
    btn_start = s; btn_clear = c; btn_lap = l;
    step();
    btn_start = 0; btn_clear = 0; btn_lap = 0;
  endtask

  task automatic ticks(input int n, input int half);
    for (int i = 0; i < n; i++) begin
      div_clk = 1'b1;
      repeat (half) step();
      div_clk = 1'b0;
      repeat (half) step();
    end
  endtask

  task automatic to_idle();
    if (running) press(1, 0, 0);
    press(0, 1, 0);
  endtask

  initial begin
    int run_len;
    model_reset();
    #2 rst_n = 1'b0;
    #1 check_eq("reset_outputs", obs_bundle(), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) step();

    // Ticks before any start must be dropped.
    ticks(5, 3);
    check_eq("no_count_idle", {8'd0, digs()}, 32'h0);

    // 150 periods -> 00:01.50, no wrap.
    wrap_cnt = 0;
    press(1, 0, 0);
    ticks(150, 3);
    check_eq("run150_digits", {8'd0, digs()}, 32'h000150);
    check_eq("run150_running", {31'd0, running}, 32'd1);
    check_eq("run150_nowrap", wrap_cnt, 0);

    // 37 ticks, pause, 20 ticks ignored, clear.
    to_idle();
    press(1, 0, 0);
    ticks(37, 2);
    press(1, 0, 0);
    ticks(20, 2);
    check_eq("pause_hold", {8'd0, digs()}, 32'h000037);
    check_eq("pause_running", {31'd0, running}, 32'd0);
    press(0, 1, 0);
    check_eq("clear_digits", {8'd0, digs()}, 32'h0);

    // Simultaneous start+clear in RUN then in PAUSE.
    press(1, 0, 0);
    ticks(5, 2);
    press(1, 1, 0);
    check_eq("run_sc_digits", {8'd0, digs()}, 32'h000005);
    check_eq("run_sc_running", {31'd0, running}, 32'd0);
    press(1, 1, 0);
    check_eq("pause_sc_digits", {8'd0, digs()}, 32'h0);
    ticks(3, 2);  // still IDLE: start was dropped
    check_eq("pause_sc_idle", {8'd0, digs()}, 32'h0);

    // Rollover from 59:59.98, preloaded while paused.
    press(1, 0, 0);
    press(1, 0, 0);
    force dut.u_m_tens.cnt_q  = 4'd5;
    force dut.u_m_ones.cnt_q  = 4'd9;
    force dut.u_s_tens.cnt_q  = 4'd5;
    force dut.u_s_ones.cnt_q  = 4'd9;
    force dut.u_cs_tens.cnt_q = 4'd9;
    force dut.u_cs_ones.cnt_q = 4'd8;
    m_cs = 359998;
    step();
    release dut.u_m_tens.cnt_q;
    release dut.u_m_ones.cnt_q;
    release dut.u_s_tens.cnt_q;
    release dut.u_s_ones.cnt_q;
    release dut.u_cs_tens.cnt_q;
    release dut.u_cs_ones.cnt_q;
    press(1, 0, 0);
    wrap_cnt = 0;
    ticks(1, 3);
    check_eq("pre_wrap", {8'd0, digs()}, 32'h595999);
    check_eq("pre_wrap_nowrap", wrap_cnt, 0);
    ticks(1, 3);
    check_eq("post_wrap", {8'd0, digs()}, 32'h0);
    check_eq("wrap_once", wrap_cnt, 1);
    check_eq("wrap_running", {31'd0, running}, 32'd1);

`ifdef STOPWATCH_LAP_EN
    to_idle();
    press(1, 0, 0);
    ticks(200, 2);
    press(0, 0, 1);
    ticks(300, 2);
    check_eq("lap_frozen", {8'd0, digs()}, 32'h000200);
    check_eq("lap_active_on", {31'd0, lap_active}, 32'd1);
    press(0, 0, 1);
    check_eq("lap_released", {8'd0, digs()}, 32'h000500);
    check_eq("lap_active_off", {31'd0, lap_active}, 32'd0);
`endif

    // Asynchronous reset mid-run at 00:12.34.
    to_idle();
    press(1, 0, 0);
    ticks(1234, 2);
    check_eq("pre_reset", {8'd0, digs()}, 32'h001234);
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_eq("async_reset", obs_bundle(), 32'd0);
    repeat (2) step();
    rst_n = 1'b1;
    ticks(10, 2);
    check_eq("post_reset_idle", {8'd0, digs()}, 32'h0);
    check_eq("post_reset_running", {31'd0, running}, 32'd0);

    // Random traffic against the model.
    run_len = 0;
    for (int i = 0; i < 3000; i++) begin
      if (run_len == 0) begin
        div_clk = ~div_clk;
        run_len = $urandom_range(1, 4);
      end
      run_len--;
      btn_start = ($urandom_range(0, 29) == 0);
      btn_clear = ($urandom_range(0, 39) == 0);
      btn_lap   = ($urandom_range(0, 19) == 0);
      step();
    end
    btn_start = 0; btn_clear = 0; btn_lap = 0;
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_ctrl.md
STOPWATCH_CTRL -- requirements
Module: stopwatch_ctrl

Interface
REQ-001 Parameter: SYNC_STAGES, 2, number of synchronizer flops on div_clk (2 or 3).
REQ-002 clk  input  1  system clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 div_clk  input  1  divided clock from the clock divider, nominally 100 Hz; treated as a data level, never as a clock.
REQ-005 btn_start  input  1  single-clk-cycle pulse (debounced upstream); run/pause toggle.
REQ-006 btn_clear  input  1  single-cycle pulse; clear request.
REQ-007 btn_lap  input  1  single-cycle pulse; lap hold toggle (see Configuration).
REQ-008 m_tens, m_ones, s_tens, s_ones, cs_tens, cs_ones  output  4 each  displayed BCD digits MM:SS.cc.
REQ-009 running  output  1  high while state is RUN.
REQ-010 wrap  output  1  one-cycle pulse on 59:59.99 -> 00:00.00 rollover.
REQ-011 lap_active  output  1  high while displayed digits are frozen.

Function
REQ-012 div_clk SHALL pass through SYNC_STAGES flops plus one edge register; a synchronized 0->1 transition SHALL produce exactly one tick pulse, one clk wide.
REQ-013 Tick latency: digits SHALL change on the clk edge 2+SYNC_STAGES cycles after the div_clk rise (4 with default).
REQ-014 FSM states IDLE, RUN, PAUSE; reset state IDLE.
REQ-015 Transitions: IDLE+start->RUN; RUN+start->PAUSE; PAUSE+start->RUN; IDLE/PAUSE+clear->IDLE with all digits 0; RUN+clear ignored.
REQ-016 Simultaneous start and clear: in IDLE/PAUSE clear wins (-> IDLE, start dropped); in RUN start acts (-> PAUSE), clear dropped.
REQ-017 Counter SHALL advance by one centisecond on a tick only when current state register is RUN; a tick coinciding with RUN->PAUSE is counted, one coinciding with PAUSE->RUN is not.
REQ-018 Digit ranges: cs_ones/cs_tens 0-9, s_ones 0-9, s_tens 0-5, m_ones 0-9, m_tens 0-5; carry ripples combinationally in one cycle.
REQ-019 At 59:59.99 a tick SHALL yield 00:00.00, assert wrap for one cycle, and remain in RUN.
REQ-020 Digit values outside range SHALL never be produced.
REQ-021 Ticks in IDLE or PAUSE SHALL be discarded, not queued.

Reset
REQ-022 Assertion of rst_n SHALL immediately force IDLE, all digits 0, running 0, wrap 0, lap_active 0, synchronizer and edge flops 0, regardless of operation in progress.
REQ-023 After release, no count occurs until a start pulse is received.

Configuration
REQ-024 Macro STOPWATCH_LAP_EN defined: btn_lap in RUN toggles lap hold; on entry the live digits are copied to a snapshot register, outputs show the snapshot and lap_active=1 while internal counting continues; second press releases, outputs follow live digits next cycle.
REQ-025 With STOPWATCH_LAP_EN: btn_lap in PAUSE releases hold only; in IDLE ignored; clear or entry to IDLE releases hold; wrap still pulses from the live count.
REQ-026 Without STOPWATCH_LAP_EN: btn_lap port present but ignored, lap_active tied 0, no snapshot registers synthesized.

Structure
REQ-027 Package stopwatch_pkg SHALL hold the state enum (IDLE, RUN, PAUSE), BCD width constant (4), and per-digit maximum constants (9, 5).
REQ-028 Sub-module bcd_digit_cnt SHALL implement one modulo-(MAX+1) BCD digit with enable, carry-in, carry-out, sync clear; instantiated six times in a carry chain.

Verification
REQ-029 Reset, start, 150 div_clk periods -> digits 00:01.50, running=1, wrap never asserted.
REQ-030 Preload run to 59:59.98, 2 ticks -> 59:59.99 then 00:00.00, wrap high exactly one cycle, running stays 1.
REQ-031 Run 37 ticks, start (pause), 20 ticks, clear -> holds 00:00.37 during pause, then 00:00.00 and IDLE.
REQ-032 In RUN, start and clear same cycle -> PAUSE, digits unchanged; in PAUSE, same -> IDLE, digits 0.
REQ-033 LAP_EN: run 200 ticks, lap, 300 ticks -> outputs 00:02.00, lap_active=1; lap again -> 00:05.00, lap_active=0.
REQ-034 rst_n asserted at 00:12.34 mid-RUN -> all outputs 0 same cycle, IDLE; subsequent ticks without start -> digits stay 0.
